soc_system_gpio_pio_ext: RTL
============================

Name: soc_system_gpio_pio_ext

Overview:
Parametrised successor to the single-register output PIO on the HPS-to-FPGA lightweight Avalon-MM bus. Provides per-bit direction, atomic set/clear of the output register, input synchronisation with edge capture and a maskable level interrupt, and a timed output-inversion pulse. It is used for debug and GPIO on the soc_system fabric.

Parameters:
DATA_WIDTH, 32, number of GPIO bits (1..32); register bits above DATA_WIDTH read 0 and ignore writes.
OUT_RESET, 0, reset value of the output data register.
DIR_RESET, 0, reset value of the direction register (1 = output).
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
SYNC_STAGES, 2, input synchroniser depth (>= 2).
PULSE_CYCLES, 16, pulse duration in clk cycles (>= 1, < 2^16).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  combinational read data, zero wait states
in_port  in  DATA_WIDTH  asynchronous pin inputs
out_port  out  DATA_WIDTH  output data to pins
oe_port  out  DATA_WIDTH  per-bit output enable, equal to the direction register
irq  out  1  level interrupt

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low on reset_n.
- Write occurs when chipselect=1 and write_n=0, effective at the next clk edge.
- Register map:
  - 0 DATA: write loads data_out. Read per bit: direction=1 gives data_out; direction=0 gives the synchronised input.
  - 1 DIRECTION: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAPTURE: read; write 1 clears the bit.
  - 4 OUTSET: write-only; data_out |= wd. Reads 0.
  - 5 OUTCLEAR: write-only; data_out &= ~wd. Reads 0.
  - 6 PULSE: write loads pulse_mask, loads the counter with PULSE_CYCLES and sets busy. Read returns pulse_mask while busy, else 0.
  - 7 STATUS: bit0 = busy, bits 31:16 = remaining count. Writes ignored.
- Reset values:
  - data_out=OUT_RESET, direction=DIR_RESET, irqmask=0, edgecapture=0.
  - pulse_mask=0, busy=0, counter=0, synchroniser stages=0.
  - out_port=OUT_RESET, oe_port=DIR_RESET, irq=0.
  - readdata follows the reset registers combinationally.
- out_port = data_out XOR (busy ? pulse_mask : 0). This is registered logic with no extra latency: the pulse is visible on the cycle after the PULSE write.
- Pulse:
  - While busy, the counter decrements each cycle.
  - When the counter reaches 1 it clears busy and pulse_mask on the next edge. The inversion therefore lasts exactly PULSE_CYCLES cycles.
  - A PULSE write while busy restarts the counter with the new mask. There is no gap and no glitch on bits common to both masks.
  - A PULSE write with wd=0 sets busy with no visible effect.
- DATA, OUTSET or OUTCLEAR writes during a pulse update the base data_out. The inversion stays applied on top.
- Input path: in_port passes through a SYNC_STAGES-deep flop chain, plus one extra delay flop for edge detection.
- Edge detection: an edge on bit i sets edgecapture[i] only when direction[i]=0. Latency is SYNC_STAGES+1 cycles from in_port to edgecapture.
- Simultaneous EDGECAPTURE clear-write and a new edge on the same bit: the set wins and the bit stays 1.
- Changing direction from 1 to 0 neither creates nor suppresses edges; detection uses the already-synchronised value.
- irq = |(edgecapture & irqmask & DATA_WIDTH mask), registered, one cycle after edgecapture or irqmask changes.
- Reads have no side effects.
- Reset mid-pulse aborts immediately: out_port returns to OUT_RESET asynchronously.

Decomposition:
- Package soc_system_gpio_pkg holds:
  - register address constants ADDR_DATA..ADDR_STATUS;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings;
  - the STATUS bit position constants.
- One sub-module, soc_system_gpio_sync: parametrised SYNC_STAGES x DATA_WIDTH synchroniser with the edge-detect delay flop. Outputs are the synced value and an edge vector.
- Pulse counter and register file live in the top module.

Test Plan:
1. Reset with OUT_RESET=0x0000_00A5, DIR_RESET=0xFF, then read addr 0,1,2,3,7 -> 0xA5 (output bits), 0xFF, 0, 0, 0; irq=0.
2. DATA=0x0F0F, OUTSET 0xF000, OUTCLEAR 0x000F -> out_port=0xFF00; reads of addr 4 and 5 return 0.
3. direction=0, irqmask=0x1, EDGE_TYPE=0: in_port[0] goes 0 then 1 -> edgecapture=0x1 after 3 cycles, irq=1 one cycle later. Write 0x1 to addr 3 -> edgecapture=0 and irq drops the following cycle.
4. Drive a rising edge on bit 0 so it lands in edgecapture on the same edge as an addr-3 clear write of 0x1 -> edgecapture[0] stays 1 and irq stays 1.
5. PULSE_CYCLES=16, DATA=0, PULSE write 0x3 -> out_port=0x3 for exactly 16 cycles, then 0. STATUS bit0=1 during the pulse and 0 after.
6. PULSE 0x1; after 10 cycles write PULSE 0x3 -> bit0 held continuously and bit1 rises. Both clear 16 cycles after the second write. Assert reset_n mid-pulse -> out_port=OUT_RESET immediately.

Source files
------------

// File: rtl/soc_system_gpio_pkg.sv
// Shared constants for the extended GPIO PIO: register map, edge-capture
// modes and STATUS field positions.
package soc_system_gpio_pkg;

  localparam logic [2:0] ADDR_DATA        = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET      = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;
  localparam logic [2:0] ADDR_PULSE       = 3'd6;
  localparam logic [2:0] ADDR_STATUS      = 3'd7;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_COUNT_LSB = 16;
  localparam int STATUS_COUNT_MSB = 31;

endpackage

// File: rtl/soc_system_gpio_sync.sv
// Multi-stage input synchroniser with one extra delay flop; edges are
// derived from the synchronised value so they are never metastable.
module soc_system_gpio_sync
  import soc_system_gpio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] async_in,
  output logic [DATA_WIDTH-1:0] synced,
  output logic [DATA_WIDTH-1:0] edges
);

  logic [DATA_WIDTH-1:0] chain [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] delayed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      delayed <= '0;
    end else begin
      chain[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      delayed <= chain[SYNC_STAGES-1];
    end
  end

  assign synced = chain[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_falling
      assign edges = ~synced & delayed;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edges = synced ^ delayed;
    end else begin : g_rising
      assign edges = synced & ~delayed;
    end
  endgenerate

endmodule

// File: rtl/soc_system_gpio_pio_ext.sv
// Avalon-MM GPIO with per-bit direction, atomic set/clear, edge capture with
// maskable level irq, and a timed output-inversion pulse.
module soc_system_gpio_pio_ext
  import soc_system_gpio_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] OUT_RESET    = 32'h0,
  parameter logic [31:0] DIR_RESET    = 32'h0,
  parameter int          EDGE_TYPE    = EDGE_RISING,
  parameter int          SYNC_STAGES  = 2,
  parameter int          PULSE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  localparam logic [DATA_WIDTH-1:0] OUT_INIT   = OUT_RESET[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] DIR_INIT   = DIR_RESET[DATA_WIDTH-1:0];
  localparam logic [15:0]           PULSE_LOAD = 16'(PULSE_CYCLES);

  logic [DATA_WIDTH-1:0] data_out, data_nxt;
  logic [DATA_WIDTH-1:0] direction, irqmask;
  logic [DATA_WIDTH-1:0] edgecapture, edge_nxt;
  logic [DATA_WIDTH-1:0] pulse_mask, mask_nxt;
  logic [DATA_WIDTH-1:0] synced, edges;
  logic [DATA_WIDTH-1:0] wd;
  logic [15:0]           count, count_nxt;
  logic                  busy, busy_nxt;
  logic                  wr;

  assign wr      = chipselect & ~write_n;
  assign wd      = writedata[DATA_WIDTH-1:0];
  assign oe_port = direction;

  soc_system_gpio_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_in(in_port),
    .synced  (synced),
    .edges   (edges)
  );

  always_comb begin
    data_nxt  = data_out;
    busy_nxt  = busy;
    mask_nxt  = pulse_mask;
    count_nxt = count;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_nxt = wd;
        ADDR_OUTSET:   data_nxt = data_out | wd;
        ADDR_OUTCLEAR: data_nxt = data_out & ~wd;
        default: ;
      endcase
    end
    // A PULSE write always restarts, so overlapping pulses never leave a gap
    if (wr && address == ADDR_PULSE) begin
      busy_nxt  = 1'b1;
      mask_nxt  = wd;
      count_nxt = PULSE_LOAD;
    end else if (busy) begin
      if (count == 16'd1) begin
        busy_nxt  = 1'b0;
        mask_nxt  = '0;
        count_nxt = '0;
      end else begin
        count_nxt = count - 16'd1;
      end
    end
  end

  // New edges take priority over a simultaneous clear
  always_comb begin
    edge_nxt = edgecapture;
    if (wr && address == ADDR_EDGECAPTURE) edge_nxt = edgecapture & ~wd;
    edge_nxt = edge_nxt | (edges & ~direction);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out    <= OUT_INIT;
      direction   <= DIR_INIT;
      irqmask     <= '0;
      edgecapture <= '0;
      pulse_mask  <= '0;
      busy        <= 1'b0;
      count       <= '0;
      out_port    <= OUT_INIT;
      irq         <= 1'b0;
    end else begin
      data_out    <= data_nxt;
      edgecapture <= edge_nxt;
      pulse_mask  <= mask_nxt;
      busy        <= busy_nxt;
      count       <= count_nxt;
      out_port    <= data_nxt ^ (busy_nxt ? mask_nxt : '0);
      irq         <= |(edgecapture & irqmask);
      if (wr && address == ADDR_DIRECTION) direction <= wd;
      if (wr && address == ADDR_IRQMASK)   irqmask   <= wd;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:        readdata = 32'((data_out & direction) | (synced & ~direction));
      ADDR_DIRECTION:   readdata = 32'(direction);
      ADDR_IRQMASK:     readdata = 32'(irqmask);
      ADDR_EDGECAPTURE: readdata = 32'(edgecapture);
      ADDR_PULSE:       readdata = busy ? 32'(pulse_mask) : 32'h0;
      ADDR_STATUS: begin
        readdata[STATUS_BUSY_BIT]                   = busy;
        readdata[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = count;
      end
      default: ;
    endcase
  end

endmodule
